// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one memory/IO bus between master 0 (CPU) and master 1
// (DMA / GPU copy engine). Each master owns a one-deep pending register; the
// FSM issues one request at a time under round-robin arbitration, routes the
// result back to the owner and aborts transfers the slave never completes.
module bus_arbiter #(
  parameter int ADDR_W  = 27,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  // master 0
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_data,
  input  logic              m0_we,
  input  logic              m0_start,
  output logic [DATA_W-1:0] m0_q,
  output logic              m0_done,
  output logic              m0_err,
  // master 1
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_data,
  input  logic              m1_we,
  input  logic              m1_start,
  output logic [DATA_W-1:0] m1_q,
  output logic              m1_done,
  output logic              m1_err,
  // downstream bus
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_we,
  output logic              bus_start,
  input  logic [DATA_W-1:0] bus_q,
  input  logic              bus_done
);

  // Watchdog counter is just wide enough to hold TIMEOUT.
  localparam int               CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              we;
  } req_t;

  // Per-master inputs gathered into arrays so both masters share one code path.
  req_t       req_in [2];
  logic [1:0] start_in;

  assign req_in[0] = {m0_addr, m0_data, m0_we};
  assign req_in[1] = {m1_addr, m1_data, m1_we};
  assign start_in  = {m1_start, m0_start};

  // Pending request registers.
  req_t       req_q [2];
  req_t       req_d [2];
  logic [1:0] valid_q, valid_d;

  // Arbitration / transfer control.
  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;
  logic             complete;
  logic             pick;

  // Registered bus-side outputs.
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_data_q, bus_data_d;
  logic              bus_we_q, bus_we_d;
  logic              bus_start_q, bus_start_d;

  // Registered master-side outputs.
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] q_q [2];
  logic [DATA_W-1:0] q_d [2];

  // Pending registers: capture a start only into an empty slot, retire on completion.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // block leaves it unassigned; that is what keeps this block latch-free.
    valid_d = valid_q;
    req_d   = req_q;
    if (complete) begin
      valid_d[owner_q] = 1'b0;
    end
    // A start seen while the slot is still full is dropped. In the cycle a
    // master's done is visible its slot is already empty, so a start there
    // is captured.
    for (int m = 0; m < 2; m++) begin
      if (start_in[m] && !valid_q[m]) begin
        valid_d[m] = 1'b1;
        req_d[m]   = req_in[m];
      end
    end
  end

  // Arbitration FSM: next state, bus drive, completion routing and watchdog.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    abort_d     = 1'b0;
    bus_addr_d  = bus_addr_q;
    bus_data_d  = bus_data_q;
    bus_we_d    = bus_we_q;
    bus_start_d = 1'b0;
    done_d      = '0;
    err_d       = '0;
    q_d         = q_q;
    complete    = 1'b0;
    pick        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|valid_q) begin
          // On a tie the master that did not go last wins; otherwise the
          // only requester is taken.
          pick        = (&valid_q) ? ~last_q : valid_q[1];
          owner_d     = pick;
          // Bus fields and the start strobe are loaded here so they appear
          // together, registered, during the ISSUE cycle.
          bus_addr_d  = req_q[pick].addr;
          bus_data_d  = req_q[pick].data;
          bus_we_d    = req_q[pick].we;
          bus_start_d = 1'b1;
          state_d     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (abort_q) begin
          // Abort was registered last cycle; it beats a bus_done arriving
          // now, which is then simply too late.
          q_d[owner_q]    = '0;
          done_d[owner_q] = 1'b1;
          err_d[owner_q]  = 1'b1;
          complete        = 1'b1;
          last_d          = owner_q;
          state_d         = ST_IDLE;
        end else if (bus_done) begin
          q_d[owner_q]    = bus_q;
          done_d[owner_q] = 1'b1;
          complete        = 1'b1;
          last_d          = owner_q;
          state_d         = ST_IDLE;
        end else if (TIMEOUT != 0) begin
          // cnt_d is this WAIT cycle's ordinal (1 in the first WAIT cycle).
          cnt_d   = cnt_q + 1'b1;
          abort_d = (cnt_d == CNT_LIMIT);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Control and output registers; everything clears asynchronously on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      bus_addr_q  <= '0;
      bus_data_q  <= '0;
      bus_we_q    <= 1'b0;
      bus_start_q <= 1'b0;
      done_q      <= '0;
      err_q       <= '0;
      q_q[0]      <= '0;
      q_q[1]      <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge value of every other flop, independent of statement order.
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      bus_addr_q  <= bus_addr_d;
      bus_data_q  <= bus_data_d;
      bus_we_q    <= bus_we_d;
      bus_start_q <= bus_start_d;
      done_q      <= done_d;
      err_q       <= err_d;
      q_q         <= q_d;
    end
  end

  // Pending request storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      // NOTE: the payload is qualified by valid_q alone, but it is only two
      // small registers, so it is reset as well to keep X out of the bus
      // fields on the first issue after reset.
      req_q[0] <= '0;
      req_q[1] <= '0;
    end else begin
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  assign bus_addr  = bus_addr_q;
  assign bus_data  = bus_data_q;
  assign bus_we    = bus_we_q;
  assign bus_start = bus_start_q;

  assign m0_q    = q_q[0];
  assign m0_done = done_q[0];
  assign m0_err  = err_q[0];
  assign m1_q    = q_q[1];
  assign m1_done = done_q[1];
  assign m1_err  = err_q[1];

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed scenarios plus a randomized two-master
// phase. Stimulus pushes expected issues/responses into queues; monitors pop
// and compare whenever the DUT presents bus_start or mN_done.
module tb_bus_arbiter;

  localparam int AW = 27;
  localparam int DW = 32;
  localparam int TO = 8;

  typedef struct {
    logic [DW-1:0] q;
    logic          err;
  } resp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          we;
  } req_t;

  logic clk = 1'b0;
  logic rst_n;

  logic [1:0][AW-1:0] m_addr;
  logic [1:0][DW-1:0] m_data;
  logic [1:0]         m_we;
  logic [1:0]         m_start;
  logic [1:0][DW-1:0] m_q;
  logic [1:0]         m_done;
  logic [1:0]         m_err;

  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_data;
  logic          bus_we;
  logic          bus_start;
  logic [DW-1:0] bus_q;
  logic          bus_done;

  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .m0_addr  (m_addr[0]),
    .m0_data  (m_data[0]),
    .m0_we    (m_we[0]),
    .m0_start (m_start[0]),
    .m0_q     (m_q[0]),
    .m0_done  (m_done[0]),
    .m0_err   (m_err[0]),
    .m1_addr  (m_addr[1]),
    .m1_data  (m_data[1]),
    .m1_we    (m_we[1]),
    .m1_start (m_start[1]),
    .m1_q     (m_q[1]),
    .m1_done  (m_done[1]),
    .m1_err   (m_err[1]),
    .bus_addr (bus_addr),
    .bus_data (bus_data),
    .bus_we   (bus_we),
    .bus_start(bus_start),
    .bus_q    (bus_q),
    .bus_done (bus_done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state.
  int          n_cmp = 0;
  int          n_bad = 0;
  resp_t       exp_q [2][$];
  req_t        iq    [2][$];
  int          ord_q [$];
  int unsigned issue_cyc [2];
  int unsigned done_cyc  [2];
  int          rst_epoch = 0;

  // Reference memory contents (model) and the slave's own storage.
  logic [DW-1:0] model_mem [logic [AW-1:0]];
  logic [DW-1:0] slave_mem [logic [AW-1:0]];
  int            slave_lat  = 3;
  bit            slave_rand = 1'b0;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive a start for master m in the current cycle; when accepted, push the
  // bus issue and the completion the specification predicts for it.
  task automatic prep(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic w, input bit accepted, input bit will_timeout);
    resp_t r;
    req_t  rq;
    m_addr[m]  = a;
    m_data[m]  = d;
    m_we[m]    = w;
    m_start[m] = 1'b1;
    if (accepted) begin
      rq.addr = a;
      rq.data = d;
      rq.we   = w;
      iq[m].push_back(rq);
      if (will_timeout) begin
        r.q   = '0;
        r.err = 1'b1;
      end else begin
        if (w) model_mem[a] = d;
        r.q   = model_mem.exists(a) ? model_mem[a] : init_val(a);
        r.err = 1'b0;
      end
      exp_q[m].push_back(r);
    end
  endtask

  task automatic pulse_end(input int m);
    @(negedge clk);
    m_start[m] = 1'b0;
  endtask

  task automatic wait_done(input int m, input int budget);
    int n = 0;
    while (!m_done[m] && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!m_done[m]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout m%0d: no done within %0d cycles", m, budget);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + iq[0].size() + iq[1].size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if ((exp_q[0].size() + exp_q[1].size() + iq[0].size() + iq[1].size()) != 0) begin
      n_bad++;
      $display("FAIL drain: %0d/%0d responses and %0d/%0d issues still outstanding",
               exp_q[0].size(), exp_q[1].size(), iq[0].size(), iq[1].size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_model();
    exp_q[0].delete();
    exp_q[1].delete();
    iq[0].delete();
    iq[1].delete();
    ord_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rst_epoch++;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Slave: answers each bus_start after a latency, storing writes and
  // returning the addressed word; also checks the bus fields were held.
  logic [AW-1:0] sl_a;
  logic [DW-1:0] sl_d;
  logic          sl_w;
  int            sl_ep;
  int            sl_n;
  initial begin
    bus_done = 1'b0;
    bus_q    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus_start === 1'b1) begin
        sl_a  = bus_addr;
        sl_d  = bus_data;
        sl_w  = bus_we;
        sl_ep = rst_epoch;
        sl_n  = slave_rand ? int'($urandom_range(1, 6)) : slave_lat;
        repeat (sl_n) @(posedge clk);
        #1;
        if (sl_w) slave_mem[sl_a] = sl_d;
        bus_q    = slave_mem.exists(sl_a) ? slave_mem[sl_a] : init_val(sl_a);
        bus_done = 1'b1;
        if (sl_ep == rst_epoch) check("bus_hold", {bus_addr, bus_data, bus_we}, {sl_a, sl_d, sl_w});
        @(posedge clk);
        #1;
        bus_done = 1'b0;
        bus_q    = $urandom;
      end
    end
  end

  // Monitor: compares completions and bus issues against the queues.
  resp_t mon_r;
  req_t  mon_rq;
  int    bm;
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (m_done[m]) begin
        done_cyc[m] = cyc;
        if (exp_q[m].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done m%0d: got q=%0h err=%0b, required no completion", m, m_q[m], m_err[m]);
        end else begin
          mon_r = exp_q[m].pop_front();
          check($sformatf("m%0d_q", m), m_q[m], mon_r.q);
          check($sformatf("m%0d_err", m), m_err[m], mon_r.err);
        end
      end
    end
    if (bus_start) begin
      if (iq[0].size() == 0 && iq[1].size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_issue: got addr=%0h, required no bus_start", bus_addr);
      end else begin
        if (iq[0].size() == 0)      bm = 1;
        else if (iq[1].size() == 0) bm = 0;
        else                        bm = (bus_addr == iq[1][0].addr) ? 1 : 0;
        mon_rq = iq[bm].pop_front();
        issue_cyc[bm] = cyc;
        check("bus_addr", bus_addr, mon_rq.addr);
        check("bus_data", bus_data, mon_rq.data);
        check("bus_we", bus_we, mon_rq.we);
        if (ord_q.size() > 0) check("grant_order", bm, ord_q.pop_front());
      end
    end
  end

  // Random traffic from one master, confined to its own address region.
  task automatic rand_master(input int m, input int count);
    logic [AW-1:0] a;
    logic [3:0]    lo;
    logic          top;
    for (int i = 0; i < count; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      lo  = 4'($urandom_range(0, 15));
      top = (m == 1);
      a   = {top, 22'h0, lo};
      prep(m, a, $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      pulse_end(m);
      wait_done(m, 100);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int unsigned s;
  int unsigned done0;
  int          w;
  initial begin
    rst_n   = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    m_we    = '0;
    m_start = '0;
    slave_mem[27'h100] = 32'hDEADBEEF;
    model_mem[27'h100] = 32'hDEADBEEF;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_flags", {m_done, m_err, bus_start, bus_we}, '0);
    check("rst_bus_addr", bus_addr, '0);
    check("rst_m_q", {m_q[1], m_q[0]}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single read with 3-cycle slave latency.
    slave_lat = 3;
    s = cyc;
    prep(0, 27'h100, 32'h0, 1'b0, 1'b1, 1'b0);
    pulse_end(0);
    wait_done(0, 50);
    #1;
    check("rd_issue_lat", issue_cyc[0] - s, 2);
    check("rd_done_lat", done_cyc[0] - issue_cyc[0], 4);
    repeat (5) @(negedge clk);
    check("rd_q_hold", m_q[0], 32'hDEADBEEF);

    // Simultaneous pair from reset, then a solo m0, then a second pair.
    do_reset();
    ord_q.push_back(0);
    ord_q.push_back(1);
    prep(0, 27'h20, 32'h11, 1'b1, 1'b1, 1'b0);
    prep(1, 27'h40, 32'h22, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    m_start = '0;
    wait_drain(100);
    ord_q.push_back(0);
    prep(0, 27'h20, 32'h0, 1'b0, 1'b1, 1'b0);
    pulse_end(0);
    wait_drain(100);
    ord_q.push_back(1);
    ord_q.push_back(0);
    prep(0, 27'h24, 32'h33, 1'b1, 1'b1, 1'b0);
    prep(1, 27'h40, 32'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    m_start = '0;
    wait_drain(100);
    check("order_drained", ord_q.size(), 0);

    // Starve check: m0 re-requests on its own done while m1 waits.
    ord_q.push_back(0);
    ord_q.push_back(1);
    ord_q.push_back(0);
    prep(0, 27'h200, 32'h5, 1'b1, 1'b1, 1'b0);
    pulse_end(0);
    prep(1, 27'h300, 32'h6, 1'b1, 1'b1, 1'b0);
    pulse_end(1);
    wait_done(0, 50);
    #1;
    done0 = done_cyc[0];
    prep(0, 27'h204, 32'h7, 1'b1, 1'b1, 1'b0);
    pulse_end(0);
    wait_drain(100);
    check("starve_gap", issue_cyc[1] - done0, 1);
    check("starve_order_drained", ord_q.size(), 0);

    // Timeout: slave answers long after the watchdog fires.
    slave_lat = 12;
    prep(1, 27'h500, 32'h0, 1'b0, 1'b1, 1'b1);
    pulse_end(1);
    wait_done(1, 50);
    #1;
    check("to_lat", done_cyc[1] - issue_cyc[1], 10);
    repeat (10) @(negedge clk);
    slave_lat = 3;

    // Duplicate start on consecutive cycles: only the first is taken.
    prep(0, 27'h600, 32'h0, 1'b0, 1'b1, 1'b0);
    pulse_end(0);
    prep(0, 27'h604, 32'h0, 1'b0, 1'b0, 1'b0);
    pulse_end(0);
    wait_drain(100);
    repeat (6) @(negedge clk);

    // Asynchronous reset during WAIT.
    prep(0, 27'h700, 32'h0, 1'b0, 1'b1, 1'b0);
    pulse_end(0);
    w = 0;
    while (!bus_start && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("rst_test_issue_seen", bus_start, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    rst_epoch++;
    clear_model();
    #1;
    check("arst_flags", {m_done, m_err, bus_start, bus_we}, '0);
    check("arst_bus_addr", bus_addr, '0);
    check("arst_bus_data", bus_data, '0);
    check("arst_m0_q", m_q[0], '0);
    check("arst_m1_q", m_q[1], '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    prep(0, 27'h100, 32'h0, 1'b0, 1'b1, 1'b0);
    pulse_end(0);
    wait_drain(100);

    // Randomized concurrent traffic from both masters.
    slave_rand = 1'b1;
    fork
      rand_master(0, 30);
      rand_master(1, 30);
    join
    wait_drain(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
